// File: rtl/vending_controller.sv
// -----------------------------------------------------------------------------
// vending_controller
//
// Main sequencing FSM of the vending machine. Accepts coins and product
// selections, tracks deposited credit, performs the price check and times the
// dispense and change-return phases. All outputs are registered and feed
// display_module directly, so the state encoding on current_state is fixed.
//
// Parameters
//   PRICE_A / PRICE_B / PRICE_C : product prices in credit units
//   MAX_AMOUNT                  : credit ceiling (<= 31)
//   TIMEOUT_CYCLES              : inactivity limit while collecting money
//   DISPENSE_CYCLES             : cycles spent in DISPENSE_PRODUCT (>= 1)
//   CHANGE_CYCLES               : cycles spent in RETURN_CHANGE (>= 1)
//
// Ports
//   clk                : clock, rising edge
//   reset              : synchronous, active-high
//   coin_valid         : one-cycle coin strobe
//   coin_value [1:0]   : 00=1, 01=2, 10=5, 11=10 units
//   select_valid       : one-cycle selection strobe
//   select_id [1:0]    : 01=A, 10=B, 11=C, 00 ignored
//   cancel             : one-cycle abort strobe
//   current_state [2:0]: FSM state (see table below)
//   current_amount[4:0]: credit held
//   product_out [1:0]  : product being dispensed, 00 = none
//   change_out [4:0]   : change being returned
//   coin_reject        : one-cycle pulse when a coin is refused
//   insufficient_funds : one-cycle pulse when a selection is too expensive
//
// State table
//   state            | meaning
//   -----------------+------------------------------------------------------
//   IDLE             | no credit held, waiting for the first coin
//   MONEY_DEPOSIT    | collecting coins, waiting for select/cancel/timeout
//   PRODUCT_SELECT   | one-cycle price check of the latched selection
//   DISPENSE_PRODUCT | product_out held for DISPENSE_CYCLES cycles
//   RETURN_CHANGE    | change_out held for CHANGE_CYCLES cycles
// -----------------------------------------------------------------------------
module vending_controller #(
    parameter int PRICE_A         = 8,
    parameter int PRICE_B         = 12,
    parameter int PRICE_C         = 15,
    parameter int MAX_AMOUNT      = 31,
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int DISPENSE_CYCLES = 4,
    parameter int CHANGE_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [1:0] coin_value,
    input  logic       select_valid,
    input  logic [1:0] select_id,
    input  logic       cancel,
    output logic [2:0] current_state,
    output logic [4:0] current_amount,
    output logic [1:0] product_out,
    output logic [4:0] change_out,
    output logic       coin_reject,
    output logic       insufficient_funds
);

    typedef enum logic [2:0] {
        IDLE             = 3'b000,
        MONEY_DEPOSIT    = 3'b001,
        PRODUCT_SELECT   = 3'b010,
        DISPENSE_PRODUCT = 3'b011,
        RETURN_CHANGE    = 3'b100
    } state_t;

    // One phase counter is shared by the timeout, dispense and change phases,
    // so it is sized for the longest of the three.
    localparam int MAX_CYC_TD = (TIMEOUT_CYCLES > DISPENSE_CYCLES) ? TIMEOUT_CYCLES : DISPENSE_CYCLES;
    localparam int MAX_CYC    = (MAX_CYC_TD > CHANGE_CYCLES) ? MAX_CYC_TD : CHANGE_CYCLES;
    localparam int CNT_W      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DISPENSE_LAST = CNT_W'(DISPENSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CHANGE_LAST   = CNT_W'(CHANGE_CYCLES - 1);
    localparam logic [5:0]       MAX_AMT_6     = 6'(MAX_AMOUNT);

    state_t           state, state_nxt;
    logic [4:0]       amount, amount_nxt;
    logic [1:0]       product, product_nxt;
    logic [4:0]       change, change_nxt;
    logic             reject, reject_nxt;
    logic             insufficient, insufficient_nxt;
    logic [1:0]       sel_id, sel_id_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic [5:0]       coin_units;
    logic [5:0]       coin_sum;
    logic             coin_fits;
    logic             first_coin_fits;
    logic [5:0]       price;
    logic             affordable;
    logic             timeout_hit;

    // Coin code to credit units.
    always_comb begin
        coin_units = 6'd0;
        case (coin_value)
            2'b00:   coin_units = 6'd1;
            2'b01:   coin_units = 6'd2;
            2'b10:   coin_units = 6'd5;
            default: coin_units = 6'd10;
        endcase
    end

    // Price of the latched selection; 6 bits so prices above the 5-bit credit
    // range still compare correctly.
    always_comb begin
        price = 6'd0;
        case (sel_id)
            2'b01:   price = 6'(PRICE_A);
            2'b10:   price = 6'(PRICE_B);
            2'b11:   price = 6'(PRICE_C);
            default: price = 6'd0;
        endcase
    end

    // Sum carried one bit wider than the credit so an overflowing coin is
    // detected instead of wrapping.
    assign coin_sum        = {1'b0, amount} + coin_units;
    assign coin_fits       = (coin_sum <= MAX_AMT_6);
    assign first_coin_fits = (coin_units <= MAX_AMT_6);
    assign affordable      = ({1'b0, amount} >= price);
    assign timeout_hit     = (cnt == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            amount       <= 5'd0;
            product      <= 2'b00;
            change       <= 5'd0;
            reject       <= 1'b0;
            insufficient <= 1'b0;
            sel_id       <= 2'b00;
            cnt          <= '0;
        end else begin
            state        <= state_nxt;
            amount       <= amount_nxt;
            product      <= product_nxt;
            change       <= change_nxt;
            reject       <= reject_nxt;
            insufficient <= insufficient_nxt;
            sel_id       <= sel_id_nxt;
            cnt          <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        amount_nxt       = amount;
        product_nxt      = product;
        change_nxt       = change;
        sel_id_nxt       = sel_id;
        cnt_nxt          = cnt;
        reject_nxt       = 1'b0;
        insufficient_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (coin_valid) begin
                    if (first_coin_fits) begin
                        amount_nxt = coin_units[4:0];
                        state_nxt  = MONEY_DEPOSIT;
                    end else begin
                        reject_nxt = 1'b1;
                    end
                end
            end

            MONEY_DEPOSIT: begin
                // Timeout takes the cancel path, so it also outranks select
                // and any coin arriving in the same cycle.
                if (cancel || timeout_hit) begin
                    change_nxt = amount;
                    amount_nxt = 5'd0;
                    state_nxt  = RETURN_CHANGE;
                    reject_nxt = coin_valid;
                end else if (select_valid && (select_id != 2'b00)) begin
                    sel_id_nxt = select_id;
                    state_nxt  = PRODUCT_SELECT;
                    reject_nxt = coin_valid;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (coin_valid) begin
                        if (coin_fits) begin
                            amount_nxt = coin_sum[4:0];
                            cnt_nxt    = '0;
                        end else begin
                            reject_nxt = 1'b1;
                        end
                    end
                end
            end

            PRODUCT_SELECT: begin
                reject_nxt = coin_valid;
                if (affordable) begin
                    // affordable implies price fits in 5 bits
                    amount_nxt  = amount - price[4:0];
                    product_nxt = sel_id;
                    state_nxt   = DISPENSE_PRODUCT;
                end else begin
                    insufficient_nxt = 1'b1;
                    state_nxt        = MONEY_DEPOSIT;
                end
            end

            DISPENSE_PRODUCT: begin
                reject_nxt = coin_valid;
                if (cnt == DISPENSE_LAST) begin
                    product_nxt = 2'b00;
                    if (amount != 5'd0) begin
                        change_nxt = amount;
                        amount_nxt = 5'd0;
                        state_nxt  = RETURN_CHANGE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            RETURN_CHANGE: begin
                reject_nxt = coin_valid;
                if (cnt == CHANGE_LAST) begin
                    change_nxt = 5'd0;
                    state_nxt  = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_nxt   = IDLE;
                amount_nxt  = 5'd0;
                product_nxt = 2'b00;
                change_nxt  = 5'd0;
            end
        endcase

        // Every state change restarts the shared phase counter.
        if (state_nxt != state) begin
            cnt_nxt = '0;
        end
    end

    assign current_state      = state;
    assign current_amount     = amount;
    assign product_out        = product;
    assign change_out         = change;
    assign coin_reject        = reject;
    assign insufficient_funds = insufficient;

endmodule

// File: tb/tb_vending_controller.sv
module tb_vending_controller;

    localparam int T_OUT  = 20;
    localparam int D_CYC  = 4;
    localparam int C_CYC  = 4;
    localparam int MAXAMT = 31;

    // Output encoding of current_state as seen by display_module.
    localparam int S_IDLE = 0;
    localparam int S_DEP  = 1;
    localparam int S_SEL  = 2;
    localparam int S_DISP = 3;
    localparam int S_CHG  = 4;

    logic       clk;
    logic       reset;
    logic       coin_valid;
    logic [1:0] coin_value;
    logic       select_valid;
    logic [1:0] select_id;
    logic       cancel;
    logic [2:0] current_state;
    logic [4:0] current_amount;
    logic [1:0] product_out;
    logic [4:0] change_out;
    logic       coin_reject;
    logic       insufficient_funds;

    vending_controller #(
        .PRICE_A(8), .PRICE_B(12), .PRICE_C(15), .MAX_AMOUNT(MAXAMT),
        .TIMEOUT_CYCLES(T_OUT), .DISPENSE_CYCLES(D_CYC), .CHANGE_CYCLES(C_CYC)
    ) dut (
        .clk(clk), .reset(reset),
        .coin_valid(coin_valid), .coin_value(coin_value),
        .select_valid(select_valid), .select_id(select_id),
        .cancel(cancel),
        .current_state(current_state), .current_amount(current_amount),
        .product_out(product_out), .change_out(change_out),
        .coin_reject(coin_reject), .insufficient_funds(insufficient_funds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int st;
        int amt;
        int prod;
        int chg;
        int rej;
        int ins;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: transaction-level view using absolute cycle stamps
    // for deadlines rather than a phase counter.
    int m_cyc = 0;
    int m_st = S_IDLE, m_amt = 0, m_prod = 0, m_chg = 0, m_id = 0;
    int m_rej = 0, m_ins = 0;
    int m_deadline = 0;
    int m_exit_at = 0;

    function automatic int units_of(input logic [1:0] cv);
        int r;
        case (cv)
            2'b00:   r = 1;
            2'b01:   r = 2;
            2'b10:   r = 5;
            default: r = 10;
        endcase
        return r;
    endfunction

    function automatic int price_of(input int id);
        int r;
        case (id)
            1:       r = 8;
            2:       r = 12;
            3:       r = 15;
            default: r = 0;
        endcase
        return r;
    endfunction

    task automatic model_step(input bit ci, input logic [1:0] cv, input bit sv,
                              input logic [1:0] sid, input bit cn, input bit rst);
        int val;
        m_cyc++;
        m_rej = 0;
        m_ins = 0;
        val = units_of(cv);
        if (rst) begin
            m_st = S_IDLE; m_amt = 0; m_prod = 0; m_chg = 0; m_id = 0;
            return;
        end
        case (m_st)
            S_IDLE: begin
                if (ci) begin
                    if (val <= MAXAMT) begin
                        m_amt = val; m_st = S_DEP; m_deadline = m_cyc + T_OUT;
                    end else m_rej = 1;
                end
            end
            S_DEP: begin
                if (cn || m_cyc == m_deadline) begin
                    m_rej = ci; m_chg = m_amt; m_amt = 0;
                    m_st = S_CHG; m_exit_at = m_cyc + C_CYC;
                end else if (sv && sid != 2'b00) begin
                    m_rej = ci; m_id = int'(sid); m_st = S_SEL;
                end else if (ci) begin
                    if (m_amt + val <= MAXAMT) begin
                        m_amt = m_amt + val; m_deadline = m_cyc + T_OUT;
                    end else m_rej = 1;
                end
            end
            S_SEL: begin
                m_rej = ci;
                if (m_amt >= price_of(m_id)) begin
                    m_amt = m_amt - price_of(m_id); m_prod = m_id;
                    m_st = S_DISP; m_exit_at = m_cyc + D_CYC;
                end else begin
                    m_ins = 1; m_st = S_DEP; m_deadline = m_cyc + T_OUT;
                end
            end
            S_DISP: begin
                m_rej = ci;
                if (m_cyc == m_exit_at) begin
                    m_prod = 0;
                    if (m_amt > 0) begin
                        m_chg = m_amt; m_amt = 0;
                        m_st = S_CHG; m_exit_at = m_cyc + C_CYC;
                    end else m_st = S_IDLE;
                end
            end
            default: begin
                m_rej = ci;
                if (m_cyc == m_exit_at) begin
                    m_chg = 0; m_st = S_IDLE;
                end
            end
        endcase
    endtask

    // Drive one cycle of stimulus and queue the response it must produce.
    task automatic drive(input bit ci, input logic [1:0] cv, input bit sv,
                         input logic [1:0] sid, input bit cn, input bit rst);
        exp_t e;
        @(negedge clk);
        coin_valid   = ci;
        coin_value   = cv;
        select_valid = sv;
        select_id    = sid;
        cancel       = cn;
        reset        = rst;
        model_step(ci, cv, sv, sid, cn, rst);
        e.cyc = m_cyc; e.st = m_st; e.amt = m_amt; e.prod = m_prod;
        e.chg = m_chg; e.rej = m_rej; e.ins = m_ins;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 2'b00, 0, 2'b00, 0, 0);
    endtask
    task automatic coin(input logic [1:0] cv);
        drive(1, cv, 0, 2'b00, 0, 0);
    endtask
    task automatic sel(input logic [1:0] id);
        drive(0, 2'b00, 1, id, 0, 0);
    endtask
    task automatic rst_cycles(input int n);
        for (int i = 0; i < n; i++) drive(0, 2'b00, 0, 2'b00, 0, 1);
    endtask

    task automatic check(input string name, input int cyc, input logic [7:0] act, input int exp);
        checks++;
        if (act !== 8'(exp)) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: the DUT presents a registered output every cycle; compare it
    // with the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("state",        e.cyc, 8'(current_state),      e.st);
                check("amount",       e.cyc, 8'(current_amount),     e.amt);
                check("product",      e.cyc, 8'(product_out),        e.prod);
                check("change",       e.cyc, 8'(change_out),         e.chg);
                check("coin_reject",  e.cyc, 8'(coin_reject),        e.rej);
                check("insufficient", e.cyc, 8'(insufficient_funds), e.ins);
            end
        end
    end

    initial begin
        coin_valid = 0; coin_value = 2'b00; select_valid = 0;
        select_id = 2'b00; cancel = 0; reset = 1;

        // reset values
        rst_cycles(2);
        // ignored strobes in IDLE
        sel(2'b01);
        drive(0, 2'b00, 0, 2'b00, 1, 0);

        // purchase with change: 10 + 5, select A
        coin(2'b11); coin(2'b10); sel(2'b01); idle(12);

        // exact payment: 10 + 2, select B
        rst_cycles(1);
        coin(2'b11); coin(2'b01); sel(2'b10); idle(8);

        // insufficient funds then top up
        rst_cycles(1);
        coin(2'b10); sel(2'b11); idle(2); coin(2'b11); sel(2'b11); idle(8);

        // overflow, select id 00 with coin, coin+cancel together
        rst_cycles(1);
        coin(2'b11); coin(2'b11); coin(2'b11); coin(2'b01);
        drive(1, 2'b00, 1, 2'b00, 0, 0);
        drive(1, 2'b01, 0, 2'b00, 1, 0);
        idle(6);

        // timeout
        rst_cycles(1);
        coin(2'b00); idle(T_OUT + C_CYC + 3);

        // reset during dispense
        coin(2'b11); sel(2'b01); idle(2); rst_cycles(1); idle(2);

        // coins presented in busy states are rejected
        coin(2'b11); coin(2'b10); sel(2'b01); coin(2'b00); coin(2'b11); idle(4); coin(2'b01); idle(4);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit ci, sv, cn, rs;
            logic [1:0] cv, sid;
            ci  = ($urandom_range(0, 99) < 30);
            cv  = 2'($urandom_range(0, 3));
            sv  = ($urandom_range(0, 99) < 12);
            sid = 2'($urandom_range(0, 3));
            cn  = ($urandom_range(0, 99) < 4);
            rs  = ($urandom_range(0, 199) < 2);
            drive(ci, cv, sv, sid, cn, rs);
        end

        idle(1);
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vending_controller.md
# vending_controller

Main sequencing FSM of the vending machine. Accepts coins and product selections, tracks the deposited credit, checks the selection against its price, and times the dispense and change-return phases. Its registered outputs `current_state`, `current_amount`, `product_out` and `change_out` drive `display_module` directly, so state encoding and output widths match that block.

## Interface
- `PRICE_A`, default 8: price of product A (01), in credit units.
- `PRICE_B`, default 12: price of product B (10).
- `PRICE_C`, default 15: price of product C (11).
- `MAX_AMOUNT`, default 31: credit ceiling; must be ≤ 31.
- `TIMEOUT_CYCLES`, default 1000: inactivity limit in MONEY_DEPOSIT.
- `DISPENSE_CYCLES`, default 4: cycles the DISPENSE_PRODUCT state is held.
- `CHANGE_CYCLES`, default 4: cycles the RETURN_CHANGE state is held.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `coin_valid` input 1: one-cycle coin strobe.
- `coin_value` input 2: coin value code; 00=1, 01=2, 10=5, 11=10 units.
- `select_valid` input 1: one-cycle selection strobe.
- `select_id` input 2: 01=A, 10=B, 11=C; 00 is ignored.
- `cancel` input 1: one-cycle abort strobe.
- `current_state` output 3: IDLE=000, MONEY_DEPOSIT=001, PRODUCT_SELECT=010, DISPENSE_PRODUCT=011, RETURN_CHANGE=100.
- `current_amount` output 5: credit held.
- `product_out` output 2: product being dispensed; 00 means none.
- `change_out` output 5: change being returned.
- `coin_reject` output 1: one-cycle pulse when a coin is not accepted.
- `insufficient_funds` output 1: one-cycle pulse when a selection costs more than the credit held.

## Operation
- **IDLE**
  - Accepted coin: `current_amount` = value, go to MONEY_DEPOSIT.
  - `select_valid` and `cancel` are ignored.
- **MONEY_DEPOSIT** (priority: cancel > select > coin)
  - `cancel`: `change_out` = `current_amount`, `current_amount` = 0, go to RETURN_CHANGE.
  - `select_valid` with `select_id` ≠ 00: latch the id, go to PRODUCT_SELECT.
  - Coin: `current_amount` += value, provided the sum is ≤ `MAX_AMOUNT`. Otherwise pulse `coin_reject` and leave the amount unchanged. The sum is computed 6 bits wide; there is no wrap.
  - A coin arriving in the same cycle as a taken cancel or select is rejected (`coin_reject` = 1).
  - Timeout counter: cleared on entry and on every accepted coin. When it reaches `TIMEOUT_CYCLES`-1 the block behaves exactly as for `cancel`.
- **PRODUCT_SELECT** (a one-cycle price check)
  - Credit ≥ price: `current_amount` −= price, `product_out` = id, go to DISPENSE_PRODUCT.
  - Credit < price: pulse `insufficient_funds`, return to MONEY_DEPOSIT with the amount unchanged and the timeout counter cleared.
- **DISPENSE_PRODUCT**
  - Held for `DISPENSE_CYCLES` cycles.
  - On exit with `current_amount` > 0: `change_out` = `current_amount`, `current_amount` = 0, `product_out` = 00, go to RETURN_CHANGE.
  - On exit with `current_amount` = 0: `product_out` = 00, go to IDLE.
- **RETURN_CHANGE**
  - Held for `CHANGE_CYCLES` cycles.
  - On exit: `change_out` = 0, go to IDLE.
- Any coin presented in PRODUCT_SELECT, DISPENSE_PRODUCT or RETURN_CHANGE is rejected.
- `select_valid` and `cancel` outside MONEY_DEPOSIT are ignored.
- A single phase counter serves the timeout, dispense and change phases. It is cleared on every state change.

## Timing
- All outputs are registered and update on the clock edge that samples the input. Latency from strobe to output is 1 cycle.
- `reset` takes priority over every input. When sampled high, on the next edge:
  - `current_state` = IDLE, `current_amount` = 0, `product_out` = 00, `change_out` = 0;
  - `coin_reject` = 0, `insufficient_funds` = 0;
  - all counters and the latched id are cleared.
- A reset mid-dispense or mid-change abandons the transaction; no change is output.
- Cycle counts from the select strobe:
  - select at edge N → PRODUCT_SELECT at N+1;
  - DISPENSE_PRODUCT from N+2 through N+1+`DISPENSE_CYCLES`;
  - RETURN_CHANGE for exactly `CHANGE_CYCLES` cycles after that;
  - then IDLE.
- `coin_reject` and `insufficient_funds` are high for exactly one cycle per event.
- Back-to-back coin strobes on consecutive cycles are each accepted.

## Test plan
- **Reset values:** assert `reset` for 2 cycles → all outputs 0 and `current_state` = 000; repeat with `reset` asserted during DISPENSE_PRODUCT → the same values next cycle.
- **Purchase with change:** coins 10 + 5 (amount 15), select A → PRODUCT_SELECT for 1 cycle, then DISPENSE_PRODUCT with `product_out` = 01 and amount 7 for 4 cycles, then RETURN_CHANGE with `change_out` = 7 for 4 cycles, then IDLE with all outputs zero.
- **Exact payment:** coins 10 + 2 (amount 12), select B → dispense with `product_out` = 10, then straight to IDLE; RETURN_CHANGE is never entered.
- **Insufficient funds:** coin 5, select C → `insufficient_funds` pulses for 1 cycle, back in MONEY_DEPOSIT with amount 5; then coin 10 and select C → dispense with amount 0.
- **Overflow and simultaneous events:** coins 10, 10, 10 (amount 30), then coin 2 → `coin_reject` = 1 and amount stays 30; next, coin and `cancel` in the same cycle → `coin_reject` = 1 and RETURN_CHANGE with `change_out` = 30.
- **Timeout:** with `TIMEOUT_CYCLES` = 20, insert coin 1 then stay idle → RETURN_CHANGE with `change_out` = 1 exactly 20 cycles after the coin's acceptance edge.
